// File: rtl/ppheavy_pkg.sv
// Shared types and default constants for the ppheavy pulse driver.
package ppheavy_pkg;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned DeadTicksDefault  = 2;
  localparam int unsigned SyncStagesDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StDeadPre,
    StOn,
    StDeadMid,
    StDis,
    StDone
  } state_e;

endpackage

// File: rtl/tick_sync.sv
// Synchronises the 10 kHz square wave into clk_sys and emits a one-cycle tick
// on each rising edge.
module tick_sync
  import ppheavy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clk_10k,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q[0] <= clk_10k;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ppheavy_pulse_driver.sv
// Drives the ppheavy power-switch gate for a programmed tick count, then
// dead-time, then the discharge gate, and reports completion with done.
module ppheavy_pulse_driver
  import ppheavy_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned DEAD_TICKS  = DeadTicksDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             clk_10k,
  input  logic             start,
  input  logic             ppheavy_en,
  input  logic             abort,
  input  logic [CNT_W-1:0] on_ticks,
  input  logic [CNT_W-1:0] dis_ticks,
  output logic             ppheavy_gate,
  output logic             dis_gate,
  output logic             busy,
  output logic             done,
  output logic             err_overlap
);

  localparam logic [CNT_W-1:0] DeadCnt = CNT_W'(DEAD_TICKS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] dis_q, dis_d;
  logic             zero_q, zero_d;
  logic             gate_q, dis_gate_q, done_q, err_q;
  logic             tick;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk_sys(clk_sys),
    .rst    (rst),
    .clk_10k(clk_10k),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    dis_d   = dis_q;
    zero_d  = 1'b0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start && ppheavy_en) begin
          if (on_ticks != '0) begin
            state_d = StDeadPre;
            on_d    = on_ticks;
            dis_d   = dis_ticks;
          end else begin
            state_d = StDone;
            zero_d  = 1'b1;
          end
        end
      end
      StDeadPre: if (tick) state_d = StOn;
      StOn: begin
        if (abort || (tick && cnt_inc == on_q)) state_d = StDeadMid;
      end
      StDeadMid: begin
        if (tick && cnt_inc == DeadCnt) state_d = (dis_q == '0) ? StDone : StDis;
      end
      StDis: if (tick && cnt_inc == dis_q) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // One shared counter, restarted on every state entry.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_inc;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      on_q       <= '0;
      dis_q      <= '0;
      zero_q     <= 1'b0;
      gate_q     <= 1'b0;
      dis_gate_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      on_q       <= on_d;
      dis_q      <= dis_d;
      zero_q     <= zero_d;
      gate_q     <= (state_d == StOn);
      dis_gate_q <= (state_d == StDis);
      // Tick-ended runs report on entry to DONE; a zero-length run reports a
      // cycle later, as it leaves DONE.
      done_q     <= ((state_d == StDone) && (state_q != StIdle)) ||
                    ((state_q == StDone) && zero_q);
      err_q      <= start && (state_q != StIdle);
    end
  end

  assign ppheavy_gate = gate_q;
  assign dis_gate     = dis_gate_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err_overlap  = err_q;

endmodule

// File: tb/tb_ppheavy_pulse_driver.sv
// Scoreboard bench: each accepted run pushes its expected pulse widths; a
// monitor measures the gate waveforms and checks them when done appears.
module tb_ppheavy_pulse_driver;

  localparam int DEAD = 2;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        clk_10k = 1'b0;
  logic        start = 1'b0;
  logic        ppheavy_en = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] on_ticks = '0;
  logic [15:0] dis_ticks = '0;
  logic        ppheavy_gate, dis_gate, busy, done, err_overlap;

  int checks = 0;
  int failures = 0;
  int half = 50;
  int cyc = 0;

  typedef struct {
    int on_w;
    int gap_w;
    int dis_w;
    int err_n;
    int done_lat;
  } exp_t;

  exp_t exp_q[$];

  // Monitor measurements for the run in progress.
  int on_w = 0, gap_w = 0, dis_w = 0, err_n = 0, overlap_n = 0;
  int start_cyc = 0, done_n = 0;
  bit seen_gate = 0, seen_dis = 0;

  ppheavy_pulse_driver dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .clk_10k     (clk_10k),
    .start       (start),
    .ppheavy_en  (ppheavy_en),
    .abort       (abort),
    .on_ticks    (on_ticks),
    .dis_ticks   (dis_ticks),
    .ppheavy_gate(ppheavy_gate),
    .dis_gate    (dis_gate),
    .busy        (busy),
    .done        (done),
    .err_overlap (err_overlap)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    forever begin
      repeat (half) @(posedge clk_sys);
      #1 clk_10k = ~clk_10k;
    end
  end

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_meas();
    on_w = 0; gap_w = 0; dis_w = 0; err_n = 0; overlap_n = 0;
    seen_gate = 0; seen_dis = 0;
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    cyc++;
    if (rst) begin
      clear_meas();
    end else begin
      if (start && ppheavy_en && !busy) start_cyc = cyc;
      if (ppheavy_gate && dis_gate) overlap_n++;
      if (err_overlap) err_n++;
      if (ppheavy_gate) begin on_w++; seen_gate = 1; end
      if (dis_gate) begin dis_w++; seen_dis = 1; end
      if (!ppheavy_gate && !dis_gate && seen_gate && !seen_dis && !done) gap_w++;
      if (done) begin
        done_n++;
        if (exp_q.size() == 0) begin
          cmp("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          cmp("on_width", on_w, e.on_w);
          if (e.gap_w >= 0) cmp("dead_gap", gap_w, e.gap_w);
          cmp("dis_width", dis_w, e.dis_w);
          cmp("err_overlap_pulses", err_n, e.err_n);
          cmp("gate_overlap", overlap_n, 0);
          if (e.done_lat >= 0) cmp("done_latency", cyc - start_cyc, e.done_lat);
        end
        clear_meas();
      end
    end
  end

  task automatic push_run(input int on, input int gap, input int dis, input int err,
                          input int lat);
    exp_t e;
    e.on_w = on; e.gap_w = gap; e.dis_w = dis; e.err_n = err; e.done_lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int on, input int dis, input bit en);
    @(posedge clk_sys);
    #1;
    start = 1'b1;
    ppheavy_en = en;
    on_ticks = 16'(on);
    dis_ticks = 16'(dis);
    @(posedge clk_sys);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (busy && n < 20000);
    cmp("idle_timeout", int'(busy), 0);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic wait_high(input bit sel_dis);
    int n = 0;
    bit got = 0;
    while (!got && n < 20000) begin
      @(negedge clk_sys);
      n++;
      got = sel_dis ? dis_gate : ppheavy_gate;
    end
    cmp(sel_dis ? "wait_dis_timeout" : "wait_gate_timeout", int'(got), 1);
  endtask

  task automatic set_period(input int h);
    half = h;
    repeat (6 * h) @(negedge clk_sys);
  endtask

  task automatic reset_mid(input bit sel_dis);
    int d0 = done_n;
    do_start(6, 4, 1);
    wait_high(sel_dis);
    repeat (150) @(negedge clk_sys);
    @(posedge clk_sys);
    #1 rst = 1'b1;
    @(posedge clk_sys);
    #1 rst = 1'b0;
    @(negedge clk_sys);
    cmp("rst_gate", int'(ppheavy_gate), 0);
    cmp("rst_dis_gate", int'(dis_gate), 0);
    cmp("rst_busy", int'(busy), 0);
    repeat (10) @(negedge clk_sys);
    cmp("rst_no_done", done_n - d0, 0);
  endtask

  initial begin
    int p, on, dis, d0;
    bit busy_seen;

    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    cmp("reset_gate", int'(ppheavy_gate), 0);
    cmp("reset_dis_gate", int'(dis_gate), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_done", int'(done), 0);
    cmp("reset_err", int'(err_overlap), 0);
    @(posedge clk_sys);
    #1 rst = 1'b0;

    // Tick period 100 cycles for the directed scenarios.
    set_period(50);
    push_run(500, 200, 300, 0, -1);
    do_start(5, 3, 1);
    wait_idle();

    // Abort two ticks into a ten-tick ON; discharge still runs in full.
    push_run(201, -1, 300, 0, -1);
    do_start(10, 3, 1);
    wait_high(0);
    repeat (200) @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    wait_idle();

    // Second start while ON.
    push_run(600, 200, 200, 1, -1);
    do_start(6, 2, 1);
    wait_high(0);
    repeat (100) @(negedge clk_sys);
    do_start(3, 1, 1);
    wait_idle();

    // Zero ON duration.
    push_run(0, 0, 0, 0, 2);
    do_start(0, 4, 1);
    wait_idle();

    // Disabled start is ignored.
    d0 = done_n;
    busy_seen = 0;
    do_start(5, 3, 0);
    repeat (8) begin
      @(negedge clk_sys);
      if (busy) busy_seen = 1;
    end
    cmp("en0_busy", int'(busy_seen), 0);
    cmp("en0_done", done_n - d0, 0);

    reset_mid(0);
    reset_mid(1);
    push_run(300, 200, 200, 0, -1);
    do_start(3, 2, 1);
    wait_idle();

    // Random durations, tick periods and start phases.
    for (int i = 0; i < 12; i++) begin
      set_period(int'($urandom_range(10, 30)));
      p = 2 * half;
      on = int'($urandom_range(1, 8));
      dis = int'($urandom_range(0, 5));
      repeat ($urandom_range(0, p)) @(negedge clk_sys);
      push_run(on * p, DEAD * p, dis * p, 0, -1);
      do_start(on, dis, 1);
      wait_idle();
    end

    cmp("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppheavy_pulse_driver.md
# ppheavy_pulse_driver

Consumer end of the heavy pre-polarisation on-timer handshake. It accepts the one-cycle `start` pulse issued by the on-timer and drives the ppheavy power-switch gate for a programmed number of 10 kHz ticks. It then inserts dead-time and drives the discharge gate, and returns a `done` pulse to the NMR state controller. It sits between the on-timer and the ppheavy H-bridge/discharge FETs, in the `clk_sys` domain.

## Interface
- `CNT_W`, 16, width of the tick counters and duration inputs
- `DEAD_TICKS`, 2, dead-time in 10 kHz ticks between gate release and discharge assertion (≥1)
- `SYNC_STAGES`, 2, flip-flop stages synchronising `clk_10k` into `clk_sys`
- `clk_sys` in 1: the single system clock; all logic is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `clk_10k` in 1: 10 kHz square wave from the divider, treated as data and synchronised internally
- `start` in 1: one-`clk_sys`-cycle request pulse from the on-timer
- `ppheavy_en` in 1: enable, sampled with `start`
- `abort` in 1: level; terminates ON early
- `on_ticks` in CNT_W: ON duration in ticks, latched at accepted `start`
- `dis_ticks` in CNT_W: discharge duration in ticks, latched at accepted `start`
- `ppheavy_gate` out 1: power-switch drive, registered
- `dis_gate` out 1: discharge drive, registered
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle completion pulse
- `err_overlap` out 1: one-cycle pulse when `start` arrives while busy

## Operation
- Tick: a rising edge of synchronised `clk_10k` gives a one-cycle `tick`.
- States: IDLE → DEAD_PRE → ON → DEAD_MID → DIS → DONE → IDLE.
- IDLE:
  - `start & ppheavy_en & on_ticks!=0`: latch durations, clear the counter, go to DEAD_PRE.
  - `start & ppheavy_en & on_ticks==0`: go directly to DONE; no gate asserted.
  - `start & !ppheavy_en`: ignored; no `done`.
- DEAD_PRE: wait 1 tick, then go to ON. This aligns ON to the tick grid.
- ON:
  - `ppheavy_gate`=1.
  - The counter increments on each tick.
  - At count==on_ticks, go to DEAD_MID.
  - `abort` high: go to DEAD_MID at the next `clk_sys` edge regardless of tick.
- DEAD_MID: both gates are 0 for DEAD_TICKS ticks.
  - If dis_ticks==0, go to DONE.
  - Otherwise go to DIS.
- DIS:
  - `dis_gate`=1 for dis_ticks ticks.
  - `abort` is ignored; discharge always completes.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` while busy: ignored. `err_overlap` pulses; the current run is unaffected.
- Invariant: `ppheavy_gate & dis_gate` is never 1. Both gates are 0 in every state except ON and DIS respectively.
- Counters saturate at all-ones and never wrap. The on_ticks=2^CNT_W−1 case terminates by the equality compare.
- Reset in any state: next cycle both gates = 0 and state = IDLE. No `done` is issued for the interrupted run.

## Timing
- Reset values: `ppheavy_gate`, `dis_gate`, `busy`, `done`, `err_overlap` are all 0; sync chain and counters are 0.
- `tick` latency: SYNC_STAGES+1 `clk_sys` cycles after the `clk_10k` rising edge.
- `busy` rises the cycle after an accepted `start`.
- Gate outputs change one `clk_sys` cycle after the tick that causes the transition.
- ON width is exactly on_ticks tick periods, ±0 `clk_sys` cycles.
- Gate-off to `dis_gate` high is exactly DEAD_TICKS ticks.
- `done` follows the last DIS tick, or the last DEAD_MID tick if dis_ticks==0, by 1 `clk_sys` cycle.
- For on_ticks==0, `done` follows the accepted `start` by 2 cycles.
- `abort`: `ppheavy_gate` falls 1 cycle after `abort` is sampled high.
- `start` and `abort` in the same cycle in IDLE: `start` is accepted and `abort` is ignored. `abort` only matters in ON.

## Structure
- Package `ppheavy_pkg`: state enum (IDLE, DEAD_PRE, ON, DEAD_MID, DIS, DONE) and the default CNT_W/DEAD_TICKS constants.
- Sub-module `tick_sync`: SYNC_STAGES-deep synchroniser plus rising-edge detector, producing `tick`.
- Top level: FSM, one shared tick counter cleared on every state entry, output registers.

## Test plan
- on_ticks=5, dis_ticks=3, DEAD_TICKS=2, `clk_10k` edge every 100 `clk_sys` cycles → gate high 500 cycles, 200-cycle gap, `dis_gate` 300 cycles, single `done`, gates never overlap.
- `abort` asserted 2 ticks into on_ticks=10 → `ppheavy_gate` falls next cycle, discharge still runs full dis_ticks, `done` issued.
- Second `start` during ON → `err_overlap` pulses once, timing of the first run unchanged, only one `done`.
- on_ticks=0 with `start` → `done` 2 cycles later, no gate activity. `start` with `ppheavy_en`=0 → no response.
- `rst` asserted mid-ON and mid-DIS → both gates 0 next cycle, `busy`=0, no `done`. A fresh `start` afterwards runs normally.
- Random on/dis values and `clk_10k` jitter → assertion `!(ppheavy_gate & dis_gate)`, and measured ON width equals on_ticks×tick period.
